// File: rtl/param_memory.sv
// Parametrised single-port RAM with en/read/write/ready handshake, abort on en drop and error flag.
// Optional access counters (rd_count/wr_count) are built when MEM_ACCESS_COUNT_EN is defined.
module param_memory #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 128,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] input_data,
    output logic [DATA_W-1:0] output_data,
    output logic              ready,
    output logic              error
`ifdef MEM_ACCESS_COUNT_EN
   ,output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      LAT_L   = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic              ready_reg, ready_next;
    logic              error_reg, error_next;
    logic [IDX_W-1:0]  idx_reg;
    logic [DATA_W-1:0] data_reg;
    logic              op_read_reg;
    logic              illegal_reg;
    logic [DATA_W-1:0] out_reg;

    logic              req_illegal;
    logic              latch;
    logic              commit;
    logic              commit_rd;
    logic              commit_wr;

    logic [DATA_W-1:0] mem [DEPTH];

    // Legality is fixed at the latch edge from the raw request inputs.
    assign req_illegal = (read == write) || ({1'b0, address} >= DEPTH_L);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ready_next = ready_reg;
        error_next = error_reg;
        latch      = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (en) begin
                    latch = 1'b1;
                    if (LAT_L == 4'd0) begin
                        state_next = DONE;
                        cnt_next   = 4'd0;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = LAT_L;
                    end
                end
            end
            WAIT: begin
                if (!en) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else if (cnt_reg == 4'd1) begin
                    state_next = DONE;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DONE: begin
                // First edge in DONE commits; afterwards ready/error hold until en drops.
                if (!ready_reg) begin
                    if (en) begin
                        commit     = 1'b1;
                        ready_next = 1'b1;
                        error_next = illegal_reg;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (!en) begin
                    ready_next = 1'b0;
                    error_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
                ready_next = 1'b0;
                error_next = 1'b0;
            end
        endcase
    end

    // A reset on the commit edge drops the pending access.
    assign commit_rd = commit && !reset && !illegal_reg && op_read_reg;
    assign commit_wr = commit && !reset && !illegal_reg && !op_read_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            ready_reg <= 1'b0;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ready_reg <= ready_next;
            error_reg <= error_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_reg     <= '0;
            data_reg    <= '0;
            op_read_reg <= 1'b0;
            illegal_reg <= 1'b0;
        end else if (latch) begin
            idx_reg     <= address[IDX_W-1:0];
            data_reg    <= input_data;
            op_read_reg <= read;
            illegal_reg <= req_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_reg <= '0;
        end else if (commit_rd) begin
            out_reg <= mem[idx_reg];
        end
    end

    // Array has no reset so it maps onto block RAM and survives reset.
    always_ff @(posedge clk) begin
        if (commit_wr) begin
            mem[idx_reg] <= data_reg;
        end
    end

    assign output_data = out_reg;
    assign ready       = ready_reg;
    assign error       = error_reg;

`ifdef MEM_ACCESS_COUNT_EN
    logic [1:0] acc_inc;
    assign acc_inc = {commit_wr, commit_rd};

    for (genvar gi = 0; gi < 2; gi++) begin : g_acc
        logic [15:0] cnt_reg;
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_reg <= 16'd0;
            end else if (acc_inc[gi]) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
        end
    end

    assign rd_count = g_acc[0].cnt_reg;
    assign wr_count = g_acc[1].cnt_reg;
`endif

endmodule

// File: tb/tb_param_memory.sv
// Scoreboard bench for param_memory: two instances (LATENCY 1 and 3) driven with directed and
// random requests; expected responses come from an array model and are checked by a monitor.
module tb_param_memory;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [1:0] en_s, rd_s, wr_s;
    logic [7:0] addr_s [2];
    logic [7:0] din_s  [2];
    logic [7:0] out0, out1;
    logic [1:0] ready_w, error_w;
`ifdef MEM_ACCESS_COUNT_EN
    logic [15:0] rdc0, wrc0, rdc1, wrc1;
`endif

    param_memory #(.DATA_W(8), .ADDR_W(8), .DEPTH(128), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .en(en_s[0]), .read(rd_s[0]), .write(wr_s[0]),
        .address(addr_s[0]), .input_data(din_s[0]), .output_data(out0),
        .ready(ready_w[0]), .error(error_w[0])
`ifdef MEM_ACCESS_COUNT_EN
       ,.rd_count(rdc0), .wr_count(wrc0)
`endif
    );

    param_memory #(.DATA_W(8), .ADDR_W(8), .DEPTH(128), .LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .en(en_s[1]), .read(rd_s[1]), .write(wr_s[1]),
        .address(addr_s[1]), .input_data(din_s[1]), .output_data(out1),
        .ready(ready_w[1]), .error(error_w[1])
`ifdef MEM_ACCESS_COUNT_EN
       ,.rd_count(rdc1), .wr_count(wrc1)
`endif
    );

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [7:0] model_mem [2][128];
    logic [7:0] model_out [2];
    int         m_rd [2];
    int         m_wr [2];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [1:0] ready_prev = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] out_of(input int k);
        return (k == 0) ? out0 : out1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon_step(input int k);
        exp_t e;
        bit   empty;
        if (ready_w[k] && !ready_prev[k]) begin
            empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready dut%0d: got ready=1 expected no response", k);
            end else begin
                if (k == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("dut%0d_error", k), 32'(error_w[k]), 32'(e.err));
                chk($sformatf("dut%0d_output_data", k), 32'(out_of(k)), 32'(e.data));
                chk($sformatf("dut%0d_ready_edge", k), cyc, e.due);
                $display("dut%0d txn: error=%0d output_data=%02h edge=%0d", k, error_w[k], out_of(k), cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) mon_step(k);
        ready_prev <= ready_w;
    end

    task automatic scramble(input int k);
        addr_s[k] = 8'($urandom);
        din_s[k]  = 8'($urandom);
        rd_s[k]   = 1'($urandom);
        wr_s[k]   = 1'($urandom);
    endtask

    // hold < 0: full request; hold > 0: en high for hold edges, then dropped during WAIT.
    task automatic do_req(input int k, input bit rd, input bit wr, input logic [7:0] a,
                          input logic [7:0] d, input int hold);
        exp_t e;
        bit   ill;
        bit   seen;
        int   lat;
        int   extra;
        lat = (k == 0) ? 1 : 3;
        en_s[k] = 1'b1; rd_s[k] = rd; wr_s[k] = wr; addr_s[k] = a; din_s[k] = d;
        if (hold < 0) begin
            ill = (rd == wr) || (a >= 8'd128);
            if (!ill && rd) begin
                model_out[k] = model_mem[k][a[6:0]];
                m_rd[k]++;
            end
            if (!ill && wr) begin
                model_mem[k][a[6:0]] = d;
                m_wr[k]++;
            end
            e.err  = ill;
            e.data = model_out[k];
            e.due  = cyc + lat + 2;
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if (ready_w[k]) seen = 1'b1;
                else            scramble(k);
            end
            if (!seen) begin
                checks++;
                errors++;
                $display("FAIL timeout dut%0d: got no ready within 40 edges expected ready", k);
            end
            extra = $urandom_range(0, 2);
            repeat (extra) begin
                @(negedge clk);
                chk($sformatf("dut%0d_ready_hold", k), 32'(ready_w[k]), 32'd1);
                chk($sformatf("dut%0d_error_hold", k), 32'(error_w[k]), 32'(ill));
            end
            en_s[k] = 1'b0;
            @(negedge clk);
            chk($sformatf("dut%0d_ready_drop", k), 32'(ready_w[k]), 32'd0);
            chk($sformatf("dut%0d_error_drop", k), 32'(error_w[k]), 32'd0);
        end else begin
            repeat (hold) begin
                @(negedge clk);
                scramble(k);
            end
            en_s[k] = 1'b0;
            @(negedge clk);
            chk($sformatf("dut%0d_abort_ready", k), 32'(ready_w[k]), 32'd0);
            $display("dut%0d txn: aborted after %0d edges", k, hold);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            model_out[k] = 8'h00;
            m_rd[k] = 0;
            m_wr[k] = 0;
        end
    endtask

    task automatic check_idle_reset(input string tag);
        chk({tag, "_ready0"}, 32'(ready_w[0]), 32'd0);
        chk({tag, "_error0"}, 32'(error_w[0]), 32'd0);
        chk({tag, "_out0"}, 32'(out0), 32'd0);
        chk({tag, "_ready1"}, 32'(ready_w[1]), 32'd0);
        chk({tag, "_error1"}, 32'(error_w[1]), 32'd0);
        chk({tag, "_out1"}, 32'(out1), 32'd0);
    endtask

    task automatic check_counts(input string tag);
`ifdef MEM_ACCESS_COUNT_EN
        chk({tag, "_rd_count0"}, 32'(rdc0), 32'(16'(m_rd[0])));
        chk({tag, "_wr_count0"}, 32'(wrc0), 32'(16'(m_wr[0])));
        chk({tag, "_rd_count1"}, 32'(rdc1), 32'(16'(m_rd[1])));
        chk({tag, "_wr_count1"}, 32'(wrc1), 32'(16'(m_wr[1])));
`else
        $display("%s: access counters not built", tag);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int         k;
        int         r;
        logic [7:0] a;
        logic [7:0] d;

        reset = 1'b1;
        en_s = 2'b00; rd_s = 2'b00; wr_s = 2'b00;
        for (int i = 0; i < 2; i++) begin
            addr_s[i] = 8'h00;
            din_s[i]  = 8'h00;
            for (int j = 0; j < 128; j++) model_mem[i][j] = 8'h00;
        end
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_reset("reset");
        reset = 1'b0;

        // Give every word a defined value through the normal write path.
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 128; j++) do_req(i, 1'b0, 1'b1, 8'(j), 8'h00, -1);

        reset = 1'b1;
        @(negedge clk);
        model_reset();
        check_idle_reset("reset_pulse");
        reset = 1'b0;

        // Counter scenario: 3 legal writes, 2 legal reads, 1 illegal.
        do_req(0, 1'b0, 1'b1, 8'd10, 8'h1A, -1);
        do_req(0, 1'b0, 1'b1, 8'd11, 8'h1B, -1);
        do_req(0, 1'b0, 1'b1, 8'd12, 8'h1C, -1);
        do_req(0, 1'b1, 1'b0, 8'd10, 8'h00, -1);
        do_req(0, 1'b1, 1'b0, 8'd11, 8'h00, -1);
        do_req(0, 1'b1, 1'b1, 8'd13, 8'hEE, -1);
        check_counts("count_scenario");

        // LATENCY=1 write then read of address 3.
        do_req(0, 1'b0, 1'b1, 8'd3, 8'hA5, -1);
        do_req(0, 1'b1, 1'b0, 8'd3, 8'h00, -1);

        // Out-of-range address: no access, and no aliasing onto address 72.
        do_req(0, 1'b1, 1'b0, 8'd200, 8'h00, -1);
        do_req(0, 1'b0, 1'b1, 8'd200, 8'h99, -1);
        do_req(0, 1'b1, 1'b0, 8'd72, 8'h00, -1);

        // read==write is illegal in both polarities.
        do_req(0, 1'b1, 1'b1, 8'd3, 8'h11, -1);
        do_req(0, 1'b0, 1'b0, 8'd3, 8'h22, -1);
        do_req(0, 1'b1, 1'b0, 8'd3, 8'h00, -1);

        // LATENCY=3 aborts, including one on the last wait edge.
        do_req(1, 1'b0, 1'b1, 8'd5, 8'h3C, 2);
        do_req(1, 1'b1, 1'b0, 8'd5, 8'h00, -1);
        do_req(1, 1'b0, 1'b1, 8'd5, 8'h3D, 3);
        do_req(1, 1'b1, 1'b0, 8'd5, 8'h00, -1);
        do_req(0, 1'b0, 1'b1, 8'd6, 8'h4E, 1);
        do_req(0, 1'b1, 1'b0, 8'd6, 8'h00, -1);

        // Reset during WAIT of a write to address 7.
        do_req(1, 1'b0, 1'b1, 8'd7, 8'h42, -1);
        en_s[1] = 1'b1; rd_s[1] = 1'b0; wr_s[1] = 1'b1; addr_s[1] = 8'd7; din_s[1] = 8'h77;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        check_idle_reset("reset_midop");
        reset = 1'b0;
        en_s[1] = 1'b0;
        @(negedge clk);
        do_req(1, 1'b1, 1'b0, 8'd7, 8'h00, -1);

        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 1);
            r = $urandom_range(0, 15);
            d = 8'($urandom);
            if ($urandom_range(0, 9) == 0) a = 8'($urandom_range(128, 255));
            else                           a = 8'($urandom_range(0, 127));
            if (r < 6)        do_req(k, 1'b1, 1'b0, a, d, -1);
            else if (r < 12)  do_req(k, 1'b0, 1'b1, a, d, -1);
            else if (r == 12) do_req(k, 1'b1, 1'b1, a, d, -1);
            else if (r == 13) do_req(k, 1'b0, 1'b0, a, d, -1);
            else              do_req(k, 1'b0, 1'b1, a, d, $urandom_range(1, (k == 0) ? 1 : 3));
        end
        check_counts("final");

        if (q0.size() != 0 || q1.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pending_responses: got %0d/%0d left expected 0/0", q0.size(), q1.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
